// File: rtl/serial_add_pkg.sv
// serial_add_pkg: state encoding and default operand width for the bit-serial adder
package serial_add_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: operand request / result handshake bundle
// RES_OVF is present only when OVF_DETECT_EN is defined
interface serial_add_ctrl_if import serial_add_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);
  logic START_VALID, START_READY, CIN, RES_VALID, RES_READY, RES_COUT, BUSY;
  logic [WIDTH-1:0] OP_A, OP_B, RES_SUM;
`ifdef OVF_DETECT_EN
  logic RES_OVF;
  modport master (output START_VALID, OP_A, OP_B, CIN, RES_READY,
                  input START_READY, RES_VALID, RES_SUM, RES_COUT, BUSY, RES_OVF);
  modport slave (input START_VALID, OP_A, OP_B, CIN, RES_READY,
                 output START_READY, RES_VALID, RES_SUM, RES_COUT, BUSY, RES_OVF);
`else
  modport master (output START_VALID, OP_A, OP_B, CIN, RES_READY,
                  input START_READY, RES_VALID, RES_SUM, RES_COUT, BUSY);
  modport slave (input START_VALID, OP_A, OP_B, CIN, RES_READY,
                 output START_READY, RES_VALID, RES_SUM, RES_COUT, BUSY);
`endif
endinterface

// File: rtl/bit_HA.sv
// bit_HA: one-bit half adder
module bit_HA (
  input  logic A,
  input  logic B,
  output logic SUM,
  output logic CO
);
  assign SUM = A ^ B;
  assign CO  = A & B;
endmodule

// File: rtl/serial_fa_cell.sv
// serial_fa_cell: combinational full adder built from two half adders
module serial_fa_cell (
  input  logic A,
  input  logic B,
  input  logic CI,
  output logic SUM,
  output logic CO
);
  logic s0, c0, c1;
  bit_HA u_ha0 (.A(A),  .B(B),  .SUM(s0),  .CO(c0));
  bit_HA u_ha1 (.A(s0), .B(CI), .SUM(SUM), .CO(c1));
  assign CO = c0 | c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: LSB-first bit-serial add scheduler around one shared full-adder cell
// OVF_DETECT_EN adds a latched two's-complement overflow flag on RES_OVF
module serial_add_ctrl import serial_add_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic CLK,
  input logic RST,
  serial_add_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, ssum_q, ssum_d, sum_q, sum_d;
  logic carry_q, carry_d, cout_q, cout_d, bit_s, bit_c, last;
  serial_fa_cell u_cell (.A(sa_q[0]), .B(sb_q[0]), .CI(carry_q), .SUM(bit_s), .CO(bit_c));
  assign last = state_q == ST_RUN && idx_q == LAST;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    carry_d = carry_q;
    ssum_d  = ssum_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: if (bus.START_VALID) begin
        state_d = ST_RUN;
        idx_d   = '0;
        sa_d    = bus.OP_A;
        sb_d    = bus.OP_B;
        carry_d = bus.CIN;
        ssum_d  = '0;
      end
      ST_RUN: begin
        idx_d   = last ? '0 : idx_q + 1'b1;
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        carry_d = bit_c;
        ssum_d  = (ssum_q >> 1) | {bit_s, {(WIDTH-1){1'b0}}};
        state_d = last ? ST_DONE : ST_RUN;
        sum_d   = last ? ssum_d : sum_q;
        cout_d  = last ? bit_c : cout_q;
      end
      ST_DONE: state_d = bus.RES_READY ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      carry_q <= 1'b0;
      ssum_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      carry_q <= carry_d;
      ssum_q  <= ssum_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
`ifdef OVF_DETECT_EN
  // carry_q during the last bit is the carry into the MSB
  logic ovf_q, ovf_d;
  assign ovf_d = last ? carry_q ^ bit_c : ovf_q;
  always_ff @(posedge CLK) ovf_q <= RST ? 1'b0 : ovf_d;
  assign bus.RES_OVF = ovf_q;
`endif
  assign bus.START_READY = state_q == ST_IDLE;
  assign bus.RES_VALID   = state_q == ST_DONE;
  assign bus.BUSY        = state_q == ST_RUN || state_q == ST_DONE;
  assign bus.RES_SUM     = sum_q;
  assign bus.RES_COUT    = cout_q;
endmodule
